// File: rtl/mod192_arbiter.sv
// rtl/mod192_arbiter.sv - round-robin sequencer sharing one pipelined mod_192 reducer among GF(p192) lanes
module mod192_arbiter #(
  parameter int N_REQ   = 4,
  parameter int ID_W    = 2,
  parameter int A_W     = 384,
  parameter int B_W     = 192,
  parameter int RED_LAT = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*A_W-1:0]   a_flat,
  output logic [N_REQ-1:0]       gnt,
  output logic [A_W-1:0]         red_a,
  output logic                   red_valid,
  input  logic [B_W-1:0]         red_b,
  input  logic                   red_finish,
  output logic [B_W-1:0]         res,
  output logic                   res_valid,
  output logic [ID_W-1:0]        res_id,
  output logic                   busy,
  output logic                   err
);

  // The reducer is not reset, so its finish flag is untrustworthy until
  // everything issued before reset has drained out of it.
  localparam logic [1:0] MASK_LOAD = 2'(RED_LAT + 1);

  logic [ID_W-1:0] ptr;
  logic            pick_any;
  logic [ID_W-1:0] pick_id;
  logic            grant_fire;

  logic [RED_LAT:0] tag_v;
  logic [ID_W-1:0]  tag_id [RED_LAT+1];

  logic [1:0] mask_cnt;
  logic       chk_en;

  // Modular increment of a requester index (works for non-power-of-two N_REQ).
  function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= N_REQ) s = s - N_REQ;
    return s[ID_W-1:0];
  endfunction

  // Round-robin search: first asserted request at or after ptr, wrapping.
  always_comb begin
    pick_any = 1'b0;
    pick_id  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!pick_any && req[wrap_add(ptr, k)]) begin
        pick_any = 1'b1;
        pick_id  = wrap_add(ptr, k);
      end
    end
  end

  assign grant_fire = pick_any && !rst;

  // One-hot grant; suppressed during reset so nothing is captured then.
  always_comb begin
    gnt = '0;
    if (grant_fire) gnt[pick_id] = 1'b1;
  end

  // Pointer moves past the winner; holds when nobody is granted.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (grant_fire) begin
      ptr <= wrap_add(pick_id, 1);
    end
  end

  // Issue register: capture the winner's operand and present it to the reducer.
  always_ff @(posedge clk) begin
    if (rst) begin
      red_a     <= '0;
      red_valid <= 1'b0;
    end else begin
      red_valid <= grant_fire;
      if (grant_fire) red_a <= a_flat[pick_id*A_W +: A_W];
    end
  end

  // Tag pipeline mirrors the reducer so the last stage lines up with red_finish.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_v <= '0;
      for (int s = 0; s <= RED_LAT; s++) tag_id[s] <= '0;
    end else begin
      tag_v[0]  <= grant_fire;
      tag_id[0] <= pick_id;
      for (int s = 1; s <= RED_LAT; s++) begin
        tag_v[s]  <= tag_v[s-1];
        tag_id[s] <= tag_id[s-1];
      end
    end
  end

  // Result register: data always follows the reducer, validity only the tags.
  always_ff @(posedge clk) begin
    if (rst) begin
      res       <= '0;
      res_valid <= 1'b0;
      res_id    <= '0;
    end else begin
      res       <= red_b;
      res_valid <= tag_v[RED_LAT];
      res_id    <= tag_id[RED_LAT];
    end
  end

  // Post-reset mask counter: the compare stays off while stale reducer
  // contents may still emerge.
  always_ff @(posedge clk) begin
    if (rst) begin
      mask_cnt <= MASK_LOAD;
    end else if (mask_cnt != 2'd0) begin
      mask_cnt <= mask_cnt - 2'd1;
    end
  end

  assign chk_en = (mask_cnt == 2'd0);

  // Sticky consistency flag between reducer finish and our own bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if (chk_en && (red_finish != tag_v[RED_LAT])) begin
      err <= 1'b1;
    end
  end

  assign busy = red_valid || (|tag_v);

endmodule

// File: tb/tb_mod192_arbiter.sv
// tb/tb_mod192_arbiter.sv - directed bench for mod192_arbiter with a 2-cycle mod p192 reducer model
module tb_mod192_arbiter;

  localparam int N_REQ = 4;
  localparam int ID_W  = 2;
  localparam int A_W   = 384;
  localparam int B_W   = 192;

  localparam logic [A_W-1:0] P = {192'h0, 192'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFFFF_FFFFFFFF};
  localparam logic [A_W-1:0] TWO_192 = {191'h0, 1'b1, 192'h0};
  localparam logic [A_W-1:0] ALL_ONES = {A_W{1'b1}};

  logic                 clk = 1'b0;
  logic                 rst;
  logic [N_REQ-1:0]     req;
  logic [N_REQ*A_W-1:0] a_flat;
  logic [N_REQ-1:0]     gnt;
  logic [A_W-1:0]       red_a;
  logic                 red_valid;
  logic [B_W-1:0]       red_b;
  logic                 red_finish;
  logic [B_W-1:0]       res;
  logic                 res_valid;
  logic [ID_W-1:0]      res_id;
  logic                 busy;
  logic                 err;

  logic                 force_fin = 1'b0;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [ID_W-1:0] cap_id  [$];
  logic [B_W-1:0]  cap_res [$];
  int              cap_cyc [$];

  mod192_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .a_flat     (a_flat),
    .gnt        (gnt),
    .red_a      (red_a),
    .red_valid  (red_valid),
    .red_b      (red_b),
    .red_finish (red_finish),
    .res        (res),
    .res_valid  (res_valid),
    .res_id     (res_id),
    .busy       (busy),
    .err        (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reducer model: fully pipelined, 2-cycle latency, no reset.
  logic           m_v0 = 1'b0;
  logic           m_v1 = 1'b0;
  logic [A_W-1:0] m_a0 = '0;
  logic [B_W-1:0] m_b1 = '0;

  always @(posedge clk) begin
    m_v0 <= red_valid;
    m_a0 <= red_a;
    m_v1 <= m_v0;
    m_b1 <= B_W'(m_a0 % P);
  end

  assign red_finish = m_v1 | force_fin;
  assign red_b      = m_b1;

  // Result capture.
  always @(negedge clk) begin
    if (res_valid) begin
      cap_id.push_back(res_id);
      cap_res.push_back(res);
      cap_cyc.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [B_W-1:0] got, input logic [B_W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic set_a(input int i, input logic [A_W-1:0] v);
    a_flat[i*A_W +: A_W] = v;
  endtask

  task automatic clear_cap();
    cap_id.delete();
    cap_res.delete();
    cap_cyc.delete();
  endtask

  initial begin
    logic [ID_W-1:0] exp_ids [5];
    logic [B_W-1:0]  exp_res3 [3];

    rst    = 1'b1;
    req    = 4'b1111;
    a_flat = '0;
    repeat (2) tick();

    // Reset state
    #1;
    chk("rst_gnt", B_W'(gnt), 0);
    chk("rst_red_valid", B_W'(red_valid), 0);
    chk("rst_red_a", B_W'(red_a), 0);
    chk("rst_res", res, 0);
    chk("rst_res_valid", B_W'(res_valid), 0);
    chk("rst_res_id", B_W'(res_id), 0);
    chk("rst_busy", B_W'(busy), 0);
    chk("rst_err", B_W'(err), 0);

    req = '0;
    rst = 1'b0;
    repeat (5) tick();
    chk("idle_err", B_W'(err), 0);
    chk("idle_busy", B_W'(busy), 0);

    // Test 1: single request from lane 2 with a = 2^192
    clear_cap();
    set_a(2, TWO_192);
    req = 4'b0100;
    #1;
    chk("t1_gnt", B_W'(gnt), 4'b0100);
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (k == 1) begin
        req = '0;
        chk("t1_red_valid", B_W'(red_valid), 1);
        chk("t1_red_a_lo", red_a[B_W-1:0], 0);
        chk("t1_red_a_hi", red_a[A_W-1:B_W], 1);
        chk("t1_busy", B_W'(busy), 1);
      end
      chk($sformatf("t1_res_valid_c%0d", k), B_W'(res_valid), (k == 4) ? 1 : 0);
      if (k == 4) begin
        chk("t1_res", res, 192'h1_0000000000000001);
        chk("t1_res_id", B_W'(res_id), 2);
      end
    end
    repeat (2) tick();

    // Test 6: lone requester 3 gets back-to-back grants (ptr=3 here), then 1001 from ptr=0
    clear_cap();
    set_a(3, 384'h33);
    set_a(0, 384'h11);
    req = 4'b1000;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("t6_lone_gnt%0d", k), B_W'(gnt), 4'b1000);
      tick();
    end
    req = 4'b1001;
    #1;
    chk("t6_pair_gnt0", B_W'(gnt), 4'b0001);
    tick();
    #1;
    chk("t6_pair_gnt1", B_W'(gnt), 4'b1000);
    tick();
    req = '0;
    repeat (6) tick();
    exp_ids = '{2'd3, 2'd3, 2'd3, 2'd0, 2'd3};
    chk("t6_count", B_W'(cap_id.size()), 5);
    for (int k = 0; k < cap_id.size() && k < 5; k++) begin
      chk($sformatf("t6_id%0d", k), B_W'(cap_id[k]), B_W'(exp_ids[k]));
      chk($sformatf("t6_res%0d", k), cap_res[k], (exp_ids[k] == 2'd3) ? 192'h33 : 192'h11);
    end

    // Test 2: all four requesting for 8 cycles from ptr=0
    clear_cap();
    for (int i = 0; i < N_REQ; i++) set_a(i, A_W'(16 + i));
    req = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk($sformatf("t2_gnt%0d", k), B_W'(gnt), B_W'(4'b0001 << (k % 4)));
      tick();
    end
    req = '0;
    repeat (6) tick();
    chk("t2_count", B_W'(cap_id.size()), 8);
    for (int k = 0; k < cap_id.size() && k < 8; k++) begin
      chk($sformatf("t2_id%0d", k), B_W'(cap_id[k]), B_W'(k % 4));
      chk($sformatf("t2_res%0d", k), cap_res[k], B_W'(16 + (k % 4)));
      chk($sformatf("t2_b2b%0d", k), B_W'(cap_cyc[k] - cap_cyc[0]), B_W'(k));
    end

    // Test 4: reset right after three grants discards them
    clear_cap();
    req = 4'b0111;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("t4_gnt%0d", k), B_W'(gnt), B_W'(4'b0001 << k));
      tick();
    end
    req = '0;
    rst = 1'b1;
    #1;
    chk("t4_busy_inflight", B_W'(busy), 1);
    tick();
    rst = 1'b0;
    chk("t4_busy_after_rst", B_W'(busy), 0);
    chk("t4_red_valid_after_rst", B_W'(red_valid), 0);
    repeat (7) tick();
    chk("t4_no_results", B_W'(cap_id.size()), 0);
    chk("t4_err_masked", B_W'(err), 0);
    req = 4'b1111;
    #1;
    chk("t4_ptr_zero", B_W'(gnt), 4'b0001);
    tick();
    req = '0;
    repeat (6) tick();

    // Test 3: lane 0 alone, back-to-back operands p, 5, 2^384-1
    clear_cap();
    exp_res3 = '{192'h0, 192'h5, 192'h1_0000000000000002_0000000000000000};
    req = 4'b0001;
    set_a(0, P);
    #1;
    chk("t3_gnt0", B_W'(gnt), 4'b0001);
    tick();
    set_a(0, 384'h5);
    #1;
    chk("t3_gnt1", B_W'(gnt), 4'b0001);
    tick();
    set_a(0, ALL_ONES);
    #1;
    chk("t3_gnt2", B_W'(gnt), 4'b0001);
    tick();
    req = '0;
    repeat (6) tick();
    chk("t3_count", B_W'(cap_id.size()), 3);
    for (int k = 0; k < cap_id.size() && k < 3; k++) begin
      chk($sformatf("t3_res%0d", k), cap_res[k], exp_res3[k]);
      chk($sformatf("t3_id%0d", k), B_W'(cap_id[k]), 0);
    end

    // Test 5: spurious finish with an empty pipeline sets sticky err
    chk("t5_err_before", B_W'(err), 0);
    force_fin = 1'b1;
    tick();
    force_fin = 1'b0;
    chk("t5_err_set", B_W'(err), 1);
    repeat (3) tick();
    chk("t5_err_sticky", B_W'(err), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_err_cleared", B_W'(err), 0);
    force_fin = 1'b1;
    tick();
    force_fin = 1'b0;
    chk("t5_mask_window", B_W'(err), 0);
    repeat (4) tick();
    chk("t5_err_quiet", B_W'(err), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
